// File: rtl/serial_add_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// serial_add_ctrl_if : request/result bus plus the shared full_adder bit cell
// Revision 1.0
// ============================================================================
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             fa_a;
  logic             fa_b;
  logic             fa_c;
  logic             fa_sum;
  logic             fa_carry;

  modport master (
    output start, a, b, cin, fa_sum, fa_carry,
    input  busy, done, sum, cout, fa_a, fa_b, fa_c
  );

  modport slave (
    input  start, a, b, cin, fa_sum, fa_carry,
    output busy, done, sum, cout, fa_a, fa_b, fa_c
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// serial_add_ctrl : bit-serial adder sequencing one external full_adder cell
// Revision 1.0
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire                 clk,
  input  wire                 rst,
  serial_add_ctrl_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result;
  logic             result_cout;
  logic             in_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {bus.fa_sum, res_sh[WIDTH-1:1]};
          carry  <= bus.fa_carry;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            result      <= {bus.fa_sum, res_sh[WIDTH-1:1]};
            result_cout <= bus.fa_carry;
            state       <= DONE;
          end
        end
        // IDLE and DONE accept a request identically; DONE falls back to IDLE
        default: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_run   = (state == RUN);
  assign bus.busy = in_run;
  assign bus.done = (state == DONE);
  assign bus.sum  = result;
  assign bus.cout = result_cout;
  assign bus.fa_a = in_run & a_sh[0];
  assign bus.fa_b = in_run & b_sh[0];
  assign bus.fa_c = in_run & carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_serial_add_ctrl : directed vectors and corner sequences, WIDTH=8 and WIDTH=2
// Revision 1.0
// ============================================================================
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_add_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  serial_add_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference full_adder cells
  assign bus.fa_sum    = bus.fa_a ^ bus.fa_b ^ bus.fa_c;
  assign bus.fa_carry  = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_c) | (bus.fa_b & bus.fa_c);
  assign bus2.fa_sum   = bus2.fa_a ^ bus2.fa_b ^ bus2.fa_c;
  assign bus2.fa_carry = (bus2.fa_a & bus2.fa_b) | (bus2.fa_a & bus2.fa_c) | (bus2.fa_b & bus2.fa_c);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issues one request; returns edges from acceptance to done and busy-cycle count
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output int lat, output int nbusy);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, nbusy, ndone, t;
    logic held_ok;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h22, 8'h11, 1'b0, 8'h33, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[9] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0;  bus.a = '0;  bus.b = '0;  bus.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_sum",  bus.sum,  0);
    check("reset_cout", bus.cout, 0);
    check("reset_fa",   {bus.fa_a, bus.fa_b, bus.fa_c}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single operations
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, nbusy);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy", i), nbusy, 8);
      check($sformatf("vec%0d_sum", i), bus.sum, vecs[i].s);
      check($sformatf("vec%0d_cout", i), bus.cout, vecs[i].co);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {bus.done, bus.busy}, 0);
    end

    // Start during RUN is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    repeat (20) begin
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_sum", bus.sum, 8'h11);
    check("busy_start_cout", bus.cout, 0);
    check("busy_start_idle", bus.busy, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midrun_busy", bus.busy, 1);
    check("midrun_fa", {bus.fa_a, bus.fa_b, bus.fa_c}, 3'b111);
    rst = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    check("async_rst_sum",  bus.sum,  0);
    check("async_rst_cout", bus.cout, 0);
    check("async_rst_fa",   {bus.fa_a, bus.fa_b, bus.fa_c}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("after_rst_no_done", ndone, 0);
    run8(8'h22, 8'h11, 1'b0, lat, nbusy);
    check("after_rst_latency", lat, 8);
    check("after_rst_sum", bus.sum, 8'h33);

    // Back-to-back with start held high
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.a = 8'h80; bus.b = 8'h80;
    t = 0;
    while (!bus.done && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b_first_latency", t, 8);
    check("b2b_first_sum", bus.sum, 8'h03);
    check("b2b_first_cout", bus.cout, 0);
    @(posedge clk); #1;
    t = 1;
    held_ok = 1'b1;
    while (!bus.done && t < 40) begin
      if (bus.sum !== 8'h03 || bus.cout !== 1'b0) held_ok = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    bus.start = 1'b0;
    check("b2b_done_spacing", t, 9);
    check("b2b_result_held", held_ok, 1);
    check("b2b_second_sum", bus.sum, 8'h00);
    check("b2b_second_cout", bus.cout, 1);
    @(posedge clk); #1;
    check("b2b_back_to_idle", {bus.busy, bus.done}, 0);

    // Exhaustive WIDTH=2
    for (int ea = 0; ea < 4; ea++) begin
      for (int eb = 0; eb < 4; eb++) begin
        for (int ec = 0; ec < 2; ec++) begin
          @(negedge clk);
          bus2.start = 1'b1; bus2.a = ea[1:0]; bus2.b = eb[1:0]; bus2.cin = ec[0];
          @(posedge clk); #1;
          bus2.start = 1'b0;
          lat = 0;
          while (!bus2.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          check($sformatf("w2_%0d_%0d_%0d_lat", ea, eb, ec), lat, 2);
          check($sformatf("w2_%0d_%0d_%0d_res", ea, eb, ec), {bus2.cout, bus2.sum}, ea + eb + ec);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
